// File: rtl/io_uart_pkg.sv
// ============================================================================
// Module   : io_uart_pkg
// Brief    : Shared encodings and frame constants for the io_uart TX/RX paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_uart_pkg;

    localparam logic [1:0] c_TX_IDLE  = 2'd0;
    localparam logic [1:0] c_TX_START = 2'd1;
    localparam logic [1:0] c_TX_DATA  = 2'd2;
    localparam logic [1:0] c_TX_STOP  = 2'd3;

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam int   c_FRAME_BITS = 10;
    localparam int   c_DATA_BITS  = c_FRAME_BITS - 2;
    localparam logic c_IDLE_LEVEL = 1'b1;

    localparam logic [2:0] c_LAST_DATA_BIT = 3'(c_DATA_BITS - 1);

    // Terminal value of a 0-based cycle counter spanning n clocks.
    function automatic logic [7:0] cnt_last(input int n);
        return 8'(n - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_uart_rx.sv
// ============================================================================
// Module   : io_uart_rx
// Brief    : Serial receiver: 2-flop synchronizer, start-bit glitch filter,
//            centre sampling and stop-bit framing check. Pulses o_done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       nclr,
    input  logic       i_rxd,
    output logic       o_done,
    output logic [7:0] o_data
);
    import io_uart_pkg::*;

    localparam logic [7:0] c_BIT_LAST  = cnt_last(CLKS_PER_BIT);
    localparam logic [7:0] c_HALF_LAST = cnt_last(CLKS_PER_BIT / 2);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [1:0] r_state;
    logic [7:0] r_clk_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_ferr;
    logic       w_due;

    // START waits half a bit so every later sample lands mid-bit.
    always_comb begin
        w_due = (r_clk_cnt == ((r_state == c_RX_START) ? c_HALF_LAST : c_BIT_LAST));
    end

    always_ff @(posedge clk) begin
        if (!nclr) begin
            r_sync1   <= c_IDLE_LEVEL;
            r_sync2   <= c_IDLE_LEVEL;
            r_prev    <= c_IDLE_LEVEL;
            r_state   <= c_RX_IDLE;
            r_clk_cnt <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            case (r_state)
                c_RX_IDLE: begin
                    if (r_prev && !r_sync2) begin
                        r_state   <= c_RX_START;
                        r_clk_cnt <= 8'd0;
                    end
                end
                c_RX_START: begin
                    if (w_due) begin
                        r_clk_cnt <= 8'd0;
                        r_bit_cnt <= 3'd0;
                        r_state   <= r_sync2 ? c_RX_IDLE : c_RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                c_RX_DATA: begin
                    if (w_due) begin
                        r_clk_cnt <= 8'd0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        if (r_bit_cnt == c_LAST_DATA_BIT) begin
                            r_state <= c_RX_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                c_RX_STOP: begin
                    // A low stop bit parks here until the line is idle again.
                    if (r_ferr) begin
                        if (r_sync2) begin
                            r_state <= c_RX_IDLE;
                            r_ferr  <= 1'b0;
                        end
                    end else if (w_due) begin
                        r_clk_cnt <= 8'd0;
                        if (r_sync2) begin
                            r_state <= c_RX_IDLE;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                default: r_state <= c_RX_IDLE;
            endcase
        end
    end

    assign o_done = (r_state == c_RX_STOP) && !r_ferr && w_due && r_sync2;
    assign o_data = r_shift;

endmodule

`default_nettype wire

// File: rtl/io_uart.sv
// ============================================================================
// Module   : io_uart
// Brief    : CPU-attached 8N1 UART with one-byte TX holding register.
//            Define IO_UART_RX_EN to build in the receiver (io_uart_rx).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_uart #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       nclr,
    input  logic       iow,
    input  logic [7:0] ioout,
    input  logic       ior,
    output logic [7:0] ioin,
    input  logic       rxd,
    output logic       txd,
    output logic       txbusy,
    output logic       txovf,
    output logic       rxvalid,
    output logic       rxovr
);
    import io_uart_pkg::*;

    localparam logic [7:0] c_BIT_LAST = cnt_last(CLKS_PER_BIT);

    logic [1:0] r_tx_state;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [7:0] r_shift;
    logic [7:0] r_tx_clk_cnt;
    logic [2:0] r_tx_bit_cnt;
    logic       r_txd;
    logic       r_txovf;

    // Writes that find the holding register empty are accepted; the TX FSM
    // only ever empties it when it is full, so the two never collide.
    always_ff @(posedge clk) begin
        if (!nclr) begin
            r_tx_state   <= c_TX_IDLE;
            r_hold       <= 8'h00;
            r_hold_full  <= 1'b0;
            r_shift      <= 8'h00;
            r_tx_clk_cnt <= 8'd0;
            r_tx_bit_cnt <= 3'd0;
            r_txd        <= c_IDLE_LEVEL;
            r_txovf      <= 1'b0;
        end else begin
            if (iow) begin
                if (r_hold_full) begin
                    r_txovf <= 1'b1;
                end else begin
                    r_hold      <= ioout;
                    r_hold_full <= 1'b1;
                end
            end
            case (r_tx_state)
                c_TX_IDLE: begin
                    if (r_hold_full) begin
                        r_shift      <= r_hold;
                        r_hold_full  <= 1'b0;
                        r_tx_clk_cnt <= 8'd0;
                        r_txd        <= 1'b0;
                        r_tx_state   <= c_TX_START;
                    end
                end
                c_TX_START: begin
                    if (r_tx_clk_cnt == c_BIT_LAST) begin
                        r_tx_clk_cnt <= 8'd0;
                        r_tx_bit_cnt <= 3'd0;
                        r_txd        <= r_shift[0];
                        r_tx_state   <= c_TX_DATA;
                    end else begin
                        r_tx_clk_cnt <= r_tx_clk_cnt + 8'd1;
                    end
                end
                c_TX_DATA: begin
                    if (r_tx_clk_cnt == c_BIT_LAST) begin
                        r_tx_clk_cnt <= 8'd0;
                        if (r_tx_bit_cnt == c_LAST_DATA_BIT) begin
                            r_txd      <= c_IDLE_LEVEL;
                            r_tx_state <= c_TX_STOP;
                        end else begin
                            r_tx_bit_cnt <= r_tx_bit_cnt + 3'd1;
                            r_shift      <= {1'b0, r_shift[7:1]};
                            r_txd        <= r_shift[1];
                        end
                    end else begin
                        r_tx_clk_cnt <= r_tx_clk_cnt + 8'd1;
                    end
                end
                c_TX_STOP: begin
                    if (r_tx_clk_cnt == c_BIT_LAST) begin
                        r_tx_clk_cnt <= 8'd0;
                        // A pending byte starts immediately: no idle gap.
                        if (r_hold_full) begin
                            r_shift     <= r_hold;
                            r_hold_full <= 1'b0;
                            r_txd       <= 1'b0;
                            r_tx_state  <= c_TX_START;
                        end else begin
                            r_tx_state <= c_TX_IDLE;
                        end
                    end else begin
                        r_tx_clk_cnt <= r_tx_clk_cnt + 8'd1;
                    end
                end
                default: r_tx_state <= c_TX_IDLE;
            endcase
        end
    end

    assign txd    = r_txd;
    assign txbusy = r_hold_full || (r_tx_state != c_TX_IDLE);
    assign txovf  = r_txovf;

`ifdef IO_UART_RX_EN
    logic       w_rx_done;
    logic [7:0] w_rx_data;
    logic [7:0] r_ioin;
    logic       r_rxvalid;
    logic       r_rxovr;

    io_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .nclr   (nclr),
        .i_rxd  (rxd),
        .o_done (w_rx_done),
        .o_data (w_rx_data)
    );

    // A read in the completion cycle frees the buffer for the new byte.
    always_ff @(posedge clk) begin
        if (!nclr) begin
            r_ioin    <= 8'h00;
            r_rxvalid <= 1'b0;
            r_rxovr   <= 1'b0;
        end else if (w_rx_done) begin
            if (!r_rxvalid || ior) begin
                r_ioin    <= w_rx_data;
                r_rxvalid <= 1'b1;
                r_rxovr   <= 1'b0;
            end else begin
                r_rxovr <= 1'b1;
            end
        end else if (ior) begin
            r_rxvalid <= 1'b0;
            r_rxovr   <= 1'b0;
        end
    end

    assign ioin    = r_ioin;
    assign rxvalid = r_rxvalid;
    assign rxovr   = r_rxovr;
`else
    logic w_unused_rx;
    assign w_unused_rx = rxd ^ ior;
    assign ioin        = 8'h00;
    assign rxvalid     = 1'b0;
    assign rxovr       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_uart.sv
// ============================================================================
// Module   : tb_io_uart
// Brief    : Self-checking bench for io_uart (CLKS_PER_BIT=4) using a
//            frame-timeline reference model plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_uart;

    localparam int CPB     = 4;
    localparam int c_FRAME = 10;
    // Edges from the first edge that sees the start bit to byte completion:
    // two synchronizer stages, half a start bit, then nine full bits.
    localparam int c_RX_LAT = 2 + CPB / 2 + 9 * CPB;

    logic       clk   = 1'b0;
    logic       nclr  = 1'b0;
    logic       iow   = 1'b0;
    logic       ior   = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] ioout = 8'h00;
    logic [7:0] ioin;
    logic       txd;
    logic       txbusy;
    logic       txovf;
    logic       rxvalid;
    logic       rxovr;

    io_uart #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .nclr    (nclr),
        .iow     (iow),
        .ioout   (ioout),
        .ior     (ior),
        .ioin    (ioin),
        .rxd     (rxd),
        .txd     (txd),
        .txbusy  (txbusy),
        .txovf   (txovf),
        .rxvalid (rxvalid),
        .rxovr   (rxovr)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic cmp_en = 1'b0;

    typedef struct {
        int         at;
        logic [7:0] b;
    } rx_ev_t;
    rx_ev_t rx_q[$];

    logic       m_hold_v = 1'b0;
    logic [7:0] m_hold   = 8'h00;
    logic       m_active = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_byte   = 8'h00;
    logic       m_ovf    = 1'b0;
    logic       m_rxvalid = 1'b0;
    logic [7:0] m_ioin   = 8'h00;
    logic       m_rxovr  = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Line level implied by the frame in flight: start 0, data LSB first, stop 1.
    function automatic logic exp_txd();
        logic [9:0] f;
        int         k;
        if (!m_active) return 1'b1;
        f = {1'b1, m_byte, 1'b0};
        k = (cyc - m_start) / CPB;
        return f[k];
    endfunction

    always @(posedge clk) begin : model
        logic       old_hold;
        logic       done;
        logic [7:0] db;
        cyc++;
        if (!nclr) begin
            m_hold_v  = 1'b0;
            m_active  = 1'b0;
            m_ovf     = 1'b0;
            m_rxvalid = 1'b0;
            m_ioin    = 8'h00;
            m_rxovr   = 1'b0;
            rx_q.delete();
        end else begin
            old_hold = m_hold_v;
            if (m_active && cyc == m_start + c_FRAME * CPB) begin
                if (old_hold) begin
                    m_start  = cyc;
                    m_byte   = m_hold;
                    m_hold_v = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (!m_active && old_hold) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_byte   = m_hold;
                m_hold_v = 1'b0;
            end
            if (iow) begin
                if (old_hold) m_ovf = 1'b1;
                else begin
                    m_hold_v = 1'b1;
                    m_hold   = ioout;
                end
            end
            done = 1'b0;
            db   = 8'h00;
            if (rx_q.size() > 0 && rx_q[0].at == cyc) begin
                done = 1'b1;
                db   = rx_q[0].b;
                void'(rx_q.pop_front());
            end
            if (done) begin
                if (!m_rxvalid || ior) begin
                    m_ioin    = db;
                    m_rxvalid = 1'b1;
                    m_rxovr   = 1'b0;
                end else begin
                    m_rxovr = 1'b1;
                end
            end else if (ior) begin
                m_rxvalid = 1'b0;
                m_rxovr   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("txd",     {7'd0, txd},     {7'd0, exp_txd()});
            chk("txbusy",  {7'd0, txbusy},  {7'd0, (m_hold_v || m_active)});
            chk("txovf",   {7'd0, txovf},   {7'd0, m_ovf});
            chk("rxvalid", {7'd0, rxvalid}, {7'd0, m_rxvalid});
            chk("rxovr",   {7'd0, rxovr},   {7'd0, m_rxovr});
            chk("ioin",    ioin,            m_ioin);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] b);
        iow   = 1'b1;
        ioout = b;
        step();
        iow   = 1'b0;
    endtask

    task automatic read_pulse();
        ior = 1'b1;
        step();
        ior = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ior_done);
        logic   [9:0] f;
        rx_ev_t       e;
        f = {stop, b, 1'b0};
`ifdef IO_UART_RX_EN
        if (stop) begin
            e.at = cyc + 1 + c_RX_LAT;
            e.b  = b;
            rx_q.push_back(e);
        end
`else
        e.at = 0;
        e.b  = 8'h00;
`endif
        for (int k = 0; k < c_FRAME; k++) begin
            rxd = f[k];
            repeat (CPB) step();
        end
        rxd = 1'b1;
        if (ior_done) read_pulse();
        else step();
        repeat (3 * CPB) step();
    endtask

    initial begin
        logic [9:0] a5;
        nclr  = 1'b0;
        iow   = 1'b1;
        ioout = 8'hFF;
        ior   = 1'b1;
        repeat (3) step();
        cmp_en = 1'b1;
        chk("rst_txd",    {7'd0, txd},     8'd1);
        chk("rst_txbusy", {7'd0, txbusy},  8'd0);
        chk("rst_rxvalid",{7'd0, rxvalid}, 8'd0);
        chk("rst_ioin",   ioin,            8'h00);
        iow  = 1'b0;
        ior  = 1'b0;
        nclr = 1'b1;
        repeat (3) step();

        // Single frame 0xA5 against a hand-written bit sequence.
        a5 = 10'b1_1010_0101_0;
        write(8'hA5);
        chk("a5_accept_txd", {7'd0, txd},    8'd1);
        chk("a5_accept_busy",{7'd0, txbusy}, 8'd1);
        for (int k = 0; k < c_FRAME; k++) begin
            for (int s = 0; s < CPB; s++) begin
                step();
                chk("a5_bit", {7'd0, txd}, {7'd0, a5[k]});
            end
        end
        step();
        chk("a5_idle_busy", {7'd0, txbusy}, 8'd0);
        repeat (4) step();

        // Back-to-back frames, third write dropped.
        write(8'h01);
        step();
        write(8'h80);
        step();
        step();
        write(8'h33);
        chk("b2b_txovf", {7'd0, txovf}, 8'd1);
        repeat (35) step();
        chk("b2b_stop1", {7'd0, txd}, 8'd1);
        step();
        chk("b2b_start2", {7'd0, txd}, 8'd0);
        repeat (50) step();
        chk("b2b_done", {7'd0, txbusy}, 8'd0);

        // Reset mid-frame, with a write held during reset.
        write(8'hC3);
        repeat (10) step();
        chk("pre_rst_ovf", {7'd0, txovf}, 8'd1);
        nclr  = 1'b0;
        iow   = 1'b1;
        ioout = 8'h5A;
        step();
        chk("midrst_txd",  {7'd0, txd},    8'd1);
        chk("midrst_busy", {7'd0, txbusy}, 8'd0);
        chk("midrst_ovf",  {7'd0, txovf},  8'd0);
        nclr = 1'b1;
        iow  = 1'b0;
        repeat (2) step();
        chk("postrst_busy", {7'd0, txbusy}, 8'd0);

`ifdef IO_UART_RX_EN
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("rx3c_valid", {7'd0, rxvalid}, 8'd1);
        chk("rx3c_data",  ioin,            8'h3C);
        read_pulse();
        chk("rx3c_read",  {7'd0, rxvalid}, 8'd0);

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("ovr_data", ioin,          8'h11);
        chk("ovr_flag", {7'd0, rxovr}, 8'd1);
        read_pulse();
        chk("ovr_clr",  {7'd0, rxovr}, 8'd0);

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        chk("coinc_data",  ioin,            8'h22);
        chk("coinc_valid", {7'd0, rxvalid}, 8'd1);
        chk("coinc_ovr",   {7'd0, rxovr},   8'd0);
        read_pulse();

        rxd = 1'b0;
        step();
        rxd = 1'b1;
        repeat (20) step();
        chk("glitch_valid", {7'd0, rxvalid}, 8'd0);

        send_frame(8'h55, 1'b0, 1'b0);
        chk("ferr_valid", {7'd0, rxvalid}, 8'd0);
        chk("ferr_hold",  ioin,            8'h22);

        send_frame(8'hA7, 1'b1, 1'b0);
        chk("recover_data", ioin, 8'hA7);
        read_pulse();
`else
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("norx_ioin",  ioin,            8'h00);
        chk("norx_valid", {7'd0, rxvalid}, 8'd0);
        read_pulse();
`endif

        repeat (5) step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
